register_file: RTL and testbench

General-purpose register file and carry flag for the 32-bit pipeline. It is the responder for the execute stage's register interface:
- three read ports, addressed by the execute stage, returning 16-bit data;
- two write ports driven by the execute stage;
- the carry flag read/write pair.

After reset, a sweep state machine clears all registers before the block reports ready. All read ports bypass same-cycle writes, so execute's blocking-assignment usage sees fresh values.

---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file_rf_read_bypass.sv | 32 +++
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared register file sizing and sweep state encoding
package register_file_pkg;
    localparam int NUM_REGS   = 64;
    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;
endpackage

// File: rtl/register_file_rf_read_bypass.sv
// rtl/register_file_rf_read_bypass.sv - one read port with two-level write forwarding
module rf_read_bypass
    import register_file_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH
) (
    input  logic          ready,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] mem_data,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr2_addr,
    input  logic [DW-1:0] wr2_data,
    input  logic          wr2_en,
    output logic [DW-1:0] rd_data
);
    // Port 1 takes priority so the forwarded value matches what the array stores on a collision.
    always_comb begin
        rd_data = '0;
        if (ready) begin
            if (wr1_en && (wr1_addr == rd_addr)) begin
                rd_data = wr1_data;
            end else if (wr2_en && (wr2_addr == rd_addr)) begin
                rd_data = wr2_data;
            end else begin
                rd_data = mem_data;
            end
        end
    end
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 64x16 register file with clear sweep, bypassed reads and carry flag
module register_file
    import register_file_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg_rd1,
    input  logic [ADDR_WIDTH-1:0] reg_rd2,
    input  logic [ADDR_WIDTH-1:0] reg_rd3,
    output logic [DATA_WIDTH-1:0] reg_rd1_out,
    output logic [DATA_WIDTH-1:0] reg_rd2_out,
    output logic [DATA_WIDTH-1:0] reg_rd3_out,
    input  logic [ADDR_WIDTH-1:0] reg_wr1,
    input  logic [ADDR_WIDTH-1:0] reg_wr2,
    input  logic [DATA_WIDTH-1:0] reg_wr1_data,
    input  logic [DATA_WIDTH-1:0] reg_wr2_data,
    input  logic                  reg_wr1_enable,
    input  logic                  reg_wr2_enable,
    input  logic                  carrybit_wr,
    input  logic                  carrybit_wr_enable,
    output logic                  carrybit,
    output logic                  rf_ready
);
    localparam int SWEEP_W = ADDR_WIDTH - 1;

    rf_state_e              state_q, state_d;
    logic [SWEEP_W-1:0]     sweep_q, sweep_d;
    logic                   carry_q, carry_d;
    logic [DATA_WIDTH-1:0]  mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  mem_d [NUM_REGS];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        carry_d = carry_q;
        mem_d   = mem_q;
        if (state_q == CLEAR) begin
            mem_d[{sweep_q, 1'b0}] = '0;
            mem_d[{sweep_q, 1'b1}] = '0;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == {SWEEP_W{1'b1}}) begin
                state_d = READY;
            end
        end else begin
            // Port 2 first so port 1 overwrites it on an address collision.
            if (reg_wr2_enable) begin
                mem_d[reg_wr2] = reg_wr2_data;
            end
            if (reg_wr1_enable) begin
                mem_d[reg_wr1] = reg_wr1_data;
            end
            if (carrybit_wr_enable) begin
                carry_d = carrybit_wr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= CLEAR;
            sweep_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            carry_q <= carry_d;
            mem_q   <= mem_d;
        end
    end

    assign rf_ready = (state_q == READY);
    assign carrybit = carry_q;

    rf_read_bypass u_rd1 (
        .ready(rf_ready), .rd_addr(reg_rd1), .mem_data(mem_q[reg_rd1]),
        .wr1_addr(reg_wr1), .wr1_data(reg_wr1_data), .wr1_en(reg_wr1_enable),
        .wr2_addr(reg_wr2), .wr2_data(reg_wr2_data), .wr2_en(reg_wr2_enable),
        .rd_data(reg_rd1_out)
    );

    rf_read_bypass u_rd2 (
        .ready(rf_ready), .rd_addr(reg_rd2), .mem_data(mem_q[reg_rd2]),
        .wr1_addr(reg_wr1), .wr1_data(reg_wr1_data), .wr1_en(reg_wr1_enable),
        .wr2_addr(reg_wr2), .wr2_data(reg_wr2_data), .wr2_en(reg_wr2_enable),
        .rd_data(reg_rd2_out)
    );

    rf_read_bypass u_rd3 (
        .ready(rf_ready), .rd_addr(reg_rd3), .mem_data(mem_q[reg_rd3]),
        .wr1_addr(reg_wr1), .wr1_data(reg_wr1_data), .wr1_en(reg_wr1_enable),
        .wr2_addr(reg_wr2), .wr2_data(reg_wr2_data), .wr2_en(reg_wr2_enable),
        .rd_data(reg_rd3_out)
    );
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  reg_rd1, reg_rd2, reg_rd3;
    logic [15:0] reg_rd1_out, reg_rd2_out, reg_rd3_out;
    logic [5:0]  reg_wr1, reg_wr2;
    logic [15:0] reg_wr1_data, reg_wr2_data;
    logic        reg_wr1_enable, reg_wr2_enable;
    logic        carrybit_wr, carrybit_wr_enable;
    logic        carrybit, rf_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        w1_en;
        logic [5:0]  w1;
        logic [15:0] w1_d;
        logic        w2_en;
        logic [5:0]  w2;
        logic [15:0] w2_d;
        logic [5:0]  r1, r2, r3;
        logic [15:0] e1, e2, e3;
    } vec_t;

    vec_t        vecs [9];
    logic [15:0] sb_q [$];

    always #5 clock = ~clock;

    register_file dut (
        .clock(clock), .reset(reset),
        .reg_rd1(reg_rd1), .reg_rd2(reg_rd2), .reg_rd3(reg_rd3),
        .reg_rd1_out(reg_rd1_out), .reg_rd2_out(reg_rd2_out), .reg_rd3_out(reg_rd3_out),
        .reg_wr1(reg_wr1), .reg_wr2(reg_wr2),
        .reg_wr1_data(reg_wr1_data), .reg_wr2_data(reg_wr2_data),
        .reg_wr1_enable(reg_wr1_enable), .reg_wr2_enable(reg_wr2_enable),
        .carrybit_wr(carrybit_wr), .carrybit_wr_enable(carrybit_wr_enable),
        .carrybit(carrybit), .rf_ready(rf_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reg_wr1_enable     = 1'b0;
        reg_wr2_enable     = 1'b0;
        carrybit_wr_enable = 1'b0;
        carrybit_wr        = 1'b0;
        reg_wr1 = '0; reg_wr2 = '0; reg_wr1_data = '0; reg_wr2_data = '0;
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rf_ready && n < 0) n = i;
            if (n >= 0) break;
        end
    endtask

    task automatic read3(input logic [5:0] a1, input logic [5:0] a2, input logic [5:0] a3,
                         input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                         input string tag);
        reg_rd1 = a1; reg_rd2 = a2; reg_rd3 = a3;
        sb_q.push_back(e1); sb_q.push_back(e2); sb_q.push_back(e3);
        #1;
        check({tag, "_rd1"}, {16'h0, reg_rd1_out}, {16'h0, sb_q.pop_front()});
        check({tag, "_rd2"}, {16'h0, reg_rd2_out}, {16'h0, sb_q.pop_front()});
        check({tag, "_rd3"}, {16'h0, reg_rd3_out}, {16'h0, sb_q.pop_front()});
    endtask

    initial begin
        int n;
        vecs[0] = '{1, 6'd5, 16'hBEEF, 0, 6'd0, 16'h0,    6'd0,  6'd5,  6'd63, 16'h0,    16'hBEEF, 16'h0};
        vecs[1] = '{0, 6'd0, 16'h0,    0, 6'd0, 16'h0,    6'd7,  6'd5,  6'd9,  16'h0,    16'hBEEF, 16'h0};
        vecs[2] = '{1, 6'd7, 16'h1111, 1, 6'd9, 16'h2222, 6'd7,  6'd9,  6'd5,  16'h1111, 16'h2222, 16'hBEEF};
        vecs[3] = '{0, 6'd0, 16'h0,    0, 6'd0, 16'h0,    6'd7,  6'd9,  6'd3,  16'h1111, 16'h2222, 16'h0};
        vecs[4] = '{1, 6'd3, 16'hAAAA, 1, 6'd3, 16'h5555, 6'd3,  6'd62, 6'd5,  16'hAAAA, 16'h0,    16'hBEEF};
        vecs[5] = '{0, 6'd0, 16'h0,    0, 6'd0, 16'h0,    6'd3,  6'd7,  6'd9,  16'hAAAA, 16'h1111, 16'h2222};
        vecs[6] = '{0, 6'd0, 16'h0,    1, 6'd62, 16'hFFFF, 6'd3, 6'd0,  6'd62, 16'hAAAA, 16'h0,    16'hFFFF};
        vecs[7] = '{0, 6'd0, 16'h0,    0, 6'd0, 16'h0,    6'd63, 6'd10, 6'd62, 16'h0,    16'h0,    16'hFFFF};
        vecs[8] = '{0, 6'd5, 16'h0,    0, 6'd5, 16'h1,    6'd5,  6'd33, 6'd63, 16'hBEEF, 16'h0,    16'h0};

        idle_inputs();
        reg_rd1 = '0; reg_rd2 = '0; reg_rd3 = '0;
        reset = 1'b0;
        repeat (3) tick();
        check("reset_ready", {31'h0, rf_ready}, 32'h0);
        check("reset_carry", {31'h0, carrybit}, 32'h0);

        // Writes and carry strobes held throughout the sweep must be dropped.
        reg_wr1 = 6'd10; reg_wr1_data = 16'h1234; reg_wr1_enable = 1'b1;
        carrybit_wr = 1'b1; carrybit_wr_enable = 1'b1;
        reg_rd1 = 6'd10;
        reset = 1'b1;
        tick();
        check("clear_rd_forced0", {16'h0, reg_rd1_out}, 32'h0);
        n = 1;
        for (int i = 2; i <= 40 && !rf_ready; i++) begin
            tick();
            n = i;
        end
        check("sweep_len", n, 32);
        idle_inputs();
        read3(6'd0, 6'd33, 6'd63, 16'h0, 16'h0, 16'h0, "post_clear");
        read3(6'd10, 6'd1, 6'd62, 16'h0, 16'h0, 16'h0, "clear_ignored");
        check("clear_carry", {31'h0, carrybit}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            reg_wr1_enable = vecs[i].w1_en; reg_wr1 = vecs[i].w1; reg_wr1_data = vecs[i].w1_d;
            reg_wr2_enable = vecs[i].w2_en; reg_wr2 = vecs[i].w2; reg_wr2_data = vecs[i].w2_d;
            read3(vecs[i].r1, vecs[i].r2, vecs[i].r3, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                  $sformatf("vec%0d", i));
            tick();
        end
        idle_inputs();

        carrybit_wr = 1'b1; carrybit_wr_enable = 1'b1;
        #1;
        check("carry_no_bypass", {31'h0, carrybit}, 32'h0);
        tick();
        check("carry_set", {31'h0, carrybit}, 32'h1);
        carrybit_wr = 1'b0; carrybit_wr_enable = 1'b0;
        tick();
        check("carry_hold", {31'h0, carrybit}, 32'h1);
        carrybit_wr_enable = 1'b1;
        tick();
        check("carry_clear", {31'h0, carrybit}, 32'h0);
        idle_inputs();

        // Restart the sweep part-way through; a full 32 edges must follow the final release.
        reset = 1'b0;
        tick();
        check("rst_ready_drop", {31'h0, rf_ready}, 32'h0);
        reset = 1'b1;
        repeat (19) tick();
        check("mid_sweep_busy", {31'h0, rf_ready}, 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_ready(n);
        check("resweep_len", n, 32);
        read3(6'd62, 6'd3, 6'd5, 16'h0, 16'h0, 16'h0, "resweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
